// File: rtl/hazard_pipe_tracker_if.sv
// Bundle of the ID-stage inputs, the branch flush and the per-stage
// destination/write-enable stream produced by hazard_pipe_tracker.
// master: the surrounding pipeline (drives ID fields, reads tracker state).
// slave : the tracker itself.
interface hazard_pipe_tracker_if;
    // ID-stage instruction fields
    logic       ID_Valid;
    logic       ID_RegWrite;
    logic       ID_MemRead;
    logic       ID_MultStart;
    logic [4:0] ID_RegisterRs;
    logic [4:0] ID_RegisterRt;
    logic [4:0] ID_RegisterRd;
    logic       Flush;

    // Tracked pipeline registers
    logic       ID_EX_RegWrite;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_RegisterRs;
    logic [4:0] ID_EX_RegisterRt;
    logic [4:0] ID_EX_RegisterRd;
    logic       EX_MEM_RegWrite;
    logic [4:0] EX_MEM_RegisterRd;
    logic       MEM_WB_RegWrite;
    logic [4:0] MEM_WB_RegisterRd;

    // Hazard outputs
    logic       Stall;
    logic       MultBusy;

    modport master (
        output ID_Valid, ID_RegWrite, ID_MemRead, ID_MultStart,
        output ID_RegisterRs, ID_RegisterRt, ID_RegisterRd, Flush,
        input  ID_EX_RegWrite, ID_EX_MemRead,
        input  ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd,
        input  EX_MEM_RegWrite, EX_MEM_RegisterRd,
        input  MEM_WB_RegWrite, MEM_WB_RegisterRd,
        input  Stall, MultBusy
    );

    modport slave (
        input  ID_Valid, ID_RegWrite, ID_MemRead, ID_MultStart,
        input  ID_RegisterRs, ID_RegisterRt, ID_RegisterRd, Flush,
        output ID_EX_RegWrite, ID_EX_MemRead,
        output ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd,
        output EX_MEM_RegWrite, EX_MEM_RegisterRd,
        output MEM_WB_RegWrite, MEM_WB_RegisterRd,
        output Stall, MultBusy
    );
endinterface

// File: rtl/hazard_pipe_tracker.sv
// hazard_pipe_tracker: tracks the ID/EX -> EX/MEM -> MEM/WB destination and
// write-enable stream for the forwarding unit, detects load-use hazards and,
// optionally, holds EX for a 4-cycle multiply/divide.
// Optional feature macro: MULTICYCLE_EN (multi-cycle EX unit with IDLE/BUSY
// state machine). Without it, ID_MultStart is ignored, MultBusy is 0 and
// multiply instructions flow as single-cycle ones.
module hazard_pipe_tracker (
    input logic                  clk,
    input logic                  reset,
    hazard_pipe_tracker_if.slave bus
);

    // ID/EX register
    logic       idex_reg_write;
    logic       idex_mem_read;
    logic [4:0] idex_rs;
    logic [4:0] idex_rt;
    logic [4:0] idex_rd;

    // EX/MEM register
    logic       exmem_reg_write;
    logic [4:0] exmem_rd;

    // MEM/WB register
    logic       memwb_reg_write;
    logic [4:0] memwb_rd;

    // Hazard / control terms
    logic       load_use;
    logic       busy;       // multi-cycle unit occupies EX this cycle
    logic       busy_exit;  // last busy cycle: multiply result leaves EX
    logic       idex_latch; // ID fields move into ID/EX at this edge
    logic       idex_hold;  // ID/EX keeps its contents at this edge
    logic       exmem_take; // EX/MEM loads ID/EX (otherwise a bubble)

    // Load-use: the load in EX produces a register the ID instruction reads.
    // A load to $0 never creates a dependency.
    always_comb begin
        load_use = bus.ID_Valid
                 & idex_mem_read
                 & (idex_rd != 5'd0)
                 & ((idex_rd == bus.ID_RegisterRs) | (idex_rd == bus.ID_RegisterRt));
    end

`ifdef MULTICYCLE_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;
    logic [1:0] cnt;
    logic [1:0] cnt_next;
    logic       idex_mult_start;

    assign busy      = (state == BUSY);
    assign busy_exit = busy & (cnt == 2'd0);

    // Next state: a multiply accepted into ID/EX starts a 4-cycle occupancy
    // (cnt 3,2,1,0); Flush is not looked at here, so it cannot disturb BUSY.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == IDLE) begin
            if (idex_latch && bus.ID_MultStart) begin
                state_next = BUSY;
                cnt_next   = 2'd3;
            end
        end else begin
            if (cnt == 2'd0) begin
                state_next = IDLE;
            end else begin
                cnt_next = cnt - 2'd1;
            end
        end
    end

    // State register; reset discards any in-flight multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // MultStart bit of ID/EX, following the same priority as the other fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_mult_start <= 1'b0;
        end else if (idex_hold) begin
            idex_mult_start <= idex_mult_start;
        end else if (idex_latch) begin
            idex_mult_start <= bus.ID_MultStart;
        end else begin
            idex_mult_start <= 1'b0;
        end
    end

    // The multiply writes back exactly once, on the exit edge of BUSY.
    assign exmem_take = ~busy | (busy_exit & idex_mult_start);
`else
    logic unused_mult_start;

    assign unused_mult_start = bus.ID_MultStart;
    assign busy              = 1'b0;
    assign busy_exit         = 1'b0;
    assign exmem_take        = 1'b1;
`endif

    // ID/EX update selection. While busy the multiply sits in ID/EX; on the
    // exit cycle it moves on to EX/MEM and ID/EX takes a bubble, because the
    // ID instruction is still stalled and will be re-presented next cycle.
    // Flush, load-use, an invalid ID slot and the exit cycle all give a bubble.
    always_comb begin
        idex_hold  = busy & ~busy_exit;
        idex_latch = ~busy & ~bus.Flush & ~load_use & bus.ID_Valid;
    end

    // ID/EX register.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_reg_write <= 1'b0;
            idex_mem_read  <= 1'b0;
            idex_rs        <= 5'd0;
            idex_rt        <= 5'd0;
            idex_rd        <= 5'd0;
        end else if (idex_hold) begin
            idex_reg_write <= idex_reg_write;
            idex_mem_read  <= idex_mem_read;
            idex_rs        <= idex_rs;
            idex_rt        <= idex_rt;
            idex_rd        <= idex_rd;
        end else if (idex_latch) begin
            idex_reg_write <= bus.ID_RegWrite;
            idex_mem_read  <= bus.ID_MemRead;
            idex_rs        <= bus.ID_RegisterRs;
            idex_rt        <= bus.ID_RegisterRt;
            idex_rd        <= bus.ID_RegisterRd;
        end else begin
            idex_reg_write <= 1'b0;
            idex_mem_read  <= 1'b0;
            idex_rs        <= 5'd0;
            idex_rt        <= 5'd0;
            idex_rd        <= 5'd0;
        end
    end

    // EX/MEM register: bubble while the multi-cycle unit holds EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            exmem_reg_write <= 1'b0;
            exmem_rd        <= 5'd0;
        end else if (exmem_take) begin
            exmem_reg_write <= idex_reg_write;
            exmem_rd        <= idex_rd;
        end else begin
            exmem_reg_write <= 1'b0;
            exmem_rd        <= 5'd0;
        end
    end

    // MEM/WB register: never stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            memwb_reg_write <= 1'b0;
            memwb_rd        <= 5'd0;
        end else begin
            memwb_reg_write <= exmem_reg_write;
            memwb_rd        <= exmem_rd;
        end
    end

    assign bus.ID_EX_RegWrite    = idex_reg_write;
    assign bus.ID_EX_MemRead     = idex_mem_read;
    assign bus.ID_EX_RegisterRs  = idex_rs;
    assign bus.ID_EX_RegisterRt  = idex_rt;
    assign bus.ID_EX_RegisterRd  = idex_rd;
    assign bus.EX_MEM_RegWrite   = exmem_reg_write;
    assign bus.EX_MEM_RegisterRd = exmem_rd;
    assign bus.MEM_WB_RegWrite   = memwb_reg_write;
    assign bus.MEM_WB_RegisterRd = memwb_rd;
    assign bus.Stall             = load_use | busy;
    assign bus.MultBusy          = busy;

endmodule

// File: doc/hazard_pipe_tracker.md
HAZARD_PIPE_TRACKER -- requirements
Module: hazard_pipe_tracker

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- ID_Valid, in, 1: the ID stage holds a real instruction.
- ID_RegWrite, in, 1: the ID instruction writes the register file.
- ID_MemRead, in, 1: the ID instruction is a load.
- ID_MultStart, in, 1: the ID instruction is a multi-cycle multiply/divide.
- ID_RegisterRs, in, 5: source register Rs of the ID instruction.
- ID_RegisterRt, in, 5: source register Rt of the ID instruction.
- ID_RegisterRd, in, 5: final destination register of the ID instruction (Rd/Rt already muxed).
- Flush, in, 1: branch taken; squash the instruction entering EX.
- ID_EX_RegWrite, out, 1: RegWrite held in the ID/EX register.
- ID_EX_MemRead, out, 1: MemRead held in the ID/EX register.
- ID_EX_RegisterRs, out, 5: Rs held in the ID/EX register.
- ID_EX_RegisterRt, out, 5: Rt held in the ID/EX register.
- ID_EX_RegisterRd, out, 5: Rd held in the ID/EX register.
- EX_MEM_RegWrite, out, 1: RegWrite held in the EX/MEM register.
- EX_MEM_RegisterRd, out, 5: Rd held in the EX/MEM register.
- MEM_WB_RegWrite, out, 1: RegWrite held in the MEM/WB register.
- MEM_WB_RegisterRd, out, 5: Rd held in the MEM/WB register.
- Stall, out, 1: freeze PC and IF/ID this cycle.
- MultBusy, out, 1: the multi-cycle unit is occupying EX.

Function
REQ-002 The block SHALL produce the destination/write-enable stream consumed by the forwarding logic: ID/EX -> EX/MEM -> MEM/WB, one stage per cycle.
REQ-003 A bubble SHALL be defined as RegWrite=0, MemRead=0, Rs=Rt=Rd=0 (and the internal MultStart bit=0).
REQ-004 The load-use hazard SHALL be computed combinationally: LoadUse = ID_Valid & ID_EX_MemRead & (ID_EX_RegisterRd != 0) & ((ID_EX_RegisterRd == ID_RegisterRs) | (ID_EX_RegisterRd == ID_RegisterRt)).
REQ-005 Stall SHALL equal LoadUse | (state == BUSY), and SHALL be combinational in the same cycle.
REQ-006 The state machine SHALL have the states IDLE and BUSY and a 2-bit down-counter cnt.
REQ-007 In IDLE, if an ID_Valid & ID_MultStart instruction is latched into ID/EX, the next state SHALL be BUSY with cnt=3; otherwise the state SHALL remain IDLE.
REQ-008 In BUSY, cnt SHALL decrement every cycle; when cnt==0 the next state SHALL be IDLE. Total EX occupancy is 4 cycles.
REQ-009 MultBusy SHALL equal (state == BUSY).
REQ-010 ID/EX update priority SHALL be: BUSY -> hold contents; else Flush -> bubble; else LoadUse -> bubble; else ID_Valid -> latch the ID fields; else bubble.
REQ-011 EX/MEM SHALL load a bubble while BUSY, and otherwise SHALL load ID_EX_RegWrite/ID_EX_RegisterRd.
REQ-012 On the BUSY exit cycle (cnt==0), EX/MEM SHALL receive the multiply's RegWrite/Rd exactly once.
REQ-013 MEM/WB SHALL always load the EX/MEM contents; it is never stalled.
REQ-014 Flush during BUSY SHALL be ignored (illegal combination; no state change due to it).
REQ-015 LoadUse and Flush in the same cycle: Flush wins, and the bubble is identical.
REQ-016 A load whose Rd is 0 SHALL never cause a stall.

Reset
REQ-017 With reset high at a clock edge, all ID/EX, EX/MEM and MEM/WB fields SHALL be 0, state SHALL be IDLE and cnt SHALL be 0; Stall and MultBusy then read 0.
REQ-018 Reset SHALL take priority over every other input, including mid-BUSY; the in-flight multiply is discarded.

Configuration
REQ-019 Macro MULTICYCLE_EN: when defined, REQ-006..REQ-012 and REQ-014 are implemented.
REQ-020 When MULTICYCLE_EN is not defined:
- no state machine is implemented;
- ID_MultStart is ignored;
- MultBusy is tied to 0;
- Stall = LoadUse;
- ID_MultStart instructions flow as single-cycle.

Verification
REQ-021 Load-use: lw $8 in ID/EX (MemRead=1, Rd=8), ID add with Rs=8, ID_Valid=1 -> Stall=1 that cycle; next cycle ID_EX_RegWrite=0 and ID_EX_RegisterRd=0; EX_MEM_RegisterRd=8.
REQ-022 Zero register: load with Rd=0 in ID/EX, ID Rs=0 -> Stall=0.
REQ-023 Multiply (MULTICYCLE_EN): mult with Rd=10 accepted at edge T -> MultBusy=1 and Stall=1 for edges T+1..T+4; EX_MEM_RegWrite=0 over that window; EX_MEM_RegisterRd=10 after the exit edge; MEM_WB_RegisterRd=10 one cycle later.
REQ-024 Flush priority: Flush=1 together with LoadUse=1 -> ID/EX becomes a bubble; Stall=1 for that cycle only.
REQ-025 Reset mid-BUSY: reset asserted when cnt=2 -> next cycle MultBusy=0, Stall=0, and all pipeline fields are 0.
REQ-026 Flow-through: 3 back-to-back ID_Valid instructions with Rd=1,2,3 and no hazards -> MEM_WB_RegisterRd reads 1,2,3 on consecutive cycles starting 3 edges after the first is latched.
